fifo_bsram_stream: RTL
======================

Name: fifo_bsram_stream

Overview:
- Block-RAM-backed streaming FIFO with full ready/valid backpressure on both sides.
- Targets any read latency and any DATA_WIDTH/MEM_DEPTH.
- A credit-controlled output skid buffer absorbs in-flight RAM reads, so no word is lost when ready_i drops.
- Adds fill level, almost-full/almost-empty flags, synchronous flush and a sticky overflow flag.
- Sits between producer and consumer stages of the video/data pipelines as the generic deep buffer.

Parameters:
- DATA_WIDTH, 11, payload width in bits (1..36).
- MEM_DEPTH, 16, RAM entries; any value >= 2, need not be a power of two.
- RD_LATENCY, 4, RAM read latency in cycles from address to registered data (>= 1).
- AFULL_THRESH, MEM_DEPTH-2, almost_full_o asserts when level_o >= this value.
- AEMPTY_THRESH, 2, almost_empty_o asserts when level_o <= this value.

Ports:
- clk_i, in, 1, single system clock.
- rst_ni, in, 1, asynchronous active-low reset.
- data_i, in, DATA_WIDTH, write payload.
- valid_i, in, 1, write request.
- ready_o, out, 1, FIFO can accept data (= !mem_full).
- data_o, out, DATA_WIDTH, head-of-queue payload.
- valid_o, out, 1, data_o valid (= skid buffer not empty).
- ready_i, in, 1, consumer accepts data_o.
- flush_i, in, 1, synchronous clear of all contents.
- level_o, out, LVL_W, total words held = mem_count + inflight + obuf_count.
- almost_full_o, out, 1, level_o >= AFULL_THRESH.
- almost_empty_o, out, 1, level_o <= AEMPTY_THRESH.
- overflow_o, out, 1, sticky: valid_i seen while ready_o=0; cleared by reset or flush.

Behaviour:
- Reset is asynchronous and active-low on rst_ni. All pointers, counters and the valid pipeline go to 0, as do data_o, valid_o and overflow_o. ready_o=1, almost_empty_o=1, almost_full_o=0.
- Pointers:
  - wr_ptr and rd_ptr each carry one extra wrap bit.
  - At MEM_DEPTH-1 a pointer wraps to {~wrap, 0}.
  - mem_empty when the pointers are equal; mem_full when addresses match and wrap bits differ.
- Write:
  - Accepted when valid_i && ready_o. The word is written to RAM at wr_ptr and wr_ptr advances the same edge.
  - An attempted write while full is dropped and sets overflow_o.
- Credit rule:
  - OBUF_DEPTH = RD_LATENCY+2.
  - rd_issue = !mem_empty && (inflight + obuf_count < OBUF_DEPTH), evaluated on registered state only.
  - Reads never depend on ready_i combinationally.
- Read pipeline:
  - A 1-bit shift register of length RD_LATENCY tracks each issued read. Its output pushes the RAM data into the skid buffer, and inflight decrements on that push.
- Skid buffer:
  - Register FIFO of OBUF_DEPTH entries with head registered onto data_o.
  - Pop on valid_o && ready_i. Push and pop in the same cycle are allowed.
  - data_o holds its value while valid_o && !ready_i.
- First-word latency:
  - Word accepted in cycle t.
  - Read issued in t+1.
  - RAM data pushed at the end of t+1+RD_LATENCY.
  - valid_o=1 from cycle t+2+RD_LATENCY.
- Throughput: one word per cycle sustained when ready_i=1 continuously.
- Simultaneous write and read on the same address cannot occur: reads only target entries written in earlier cycles.
- Flush:
  - flush_i=1 clears pointers, skid buffer, counters and overflow_o at the next edge.
  - In-flight reads are discarded because the valid pipeline is zeroed.
  - Writes in the flush cycle are ignored; ready_o stays 1 after a flush.
  - Flush has priority over all other events.
- Reset mid-operation: everything returns immediately (asynchronously) to reset values; RAM contents are don't-care.
- level_o changes:
  - +1 on an accepted write, -1 on a pop, no change when both happen in the same cycle.
  - Range 0..MEM_DEPTH+OBUF_DEPTH.
  - ready_o depends only on mem_full, so the total held can exceed MEM_DEPTH by up to OBUF_DEPTH.

Decomposition:
- Shared package/header fifo_pkg holds:
  - PTR_W = $clog2(MEM_DEPTH)
  - OBUF_DEPTH = RD_LATENCY+2
  - OBUF_W = $clog2(OBUF_DEPTH+1)
  - LVL_W = $clog2(MEM_DEPTH+OBUF_DEPTH+1)
  - the pointer-increment-with-wrap function.
- One sub-module, bsram_sdp: an inferred simple-dual-port RAM with write port A and read port B.
  - Registered output, total read latency RD_LATENCY; no reset on the data path.
- Top level contains pointers, credit counters, valid pipeline and skid buffer.

Test Plan:
- Defaults, ready_i=1: write 0x001..0x010 back-to-back.
  - ready_o falls only if the RAM fills; the first valid_o appears 6 cycles after the first write.
  - Output is 0x001..0x010 in order with no gaps after the first word.
- Backpressure: stream 0x100..0x13F while toggling ready_i 1/0 every 3 cycles.
  - All 64 words come out in order with none duplicated or lost.
  - data_o is stable whenever valid_o && !ready_i.
- Fill: ready_i=0, write until ready_o=0.
  - level_o=MEM_DEPTH+OBUF_DEPTH=22.
  - Then pulse valid_i once: overflow_o=1 and level_o stays 22.
- Thresholds: fill to level 14 (AFULL_THRESH) then pop down to 2. almost_full_o is set at 14; almost_empty_o is set at 2.
- Flush with 3 reads in flight and valid_i=1.
  - Next cycle: level_o=0, valid_o=0, overflow_o=0.
  - No stale word appears during the following 10 cycles.
- Async reset: assert rst_ni=0 mid-cycle with valid_o=1. valid_o and level_o go to 0 immediately without a clock edge.
- Wrap: run with MEM_DEPTH=5, RD_LATENCY=1 and 40 random-gap words; output matches a reference queue exactly.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared sizing helpers and pointer arithmetic for the
//               block-RAM streaming FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Address width of the RAM (pointer width without the wrap bit)
    function automatic int unsigned calc_ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Skid buffer depth: one slot per in-flight read plus two of slack
    function automatic int unsigned calc_obuf_depth(input int unsigned rd_lat);
        return rd_lat + 2;
    endfunction

    // Width of the skid buffer occupancy and in-flight counters
    function automatic int unsigned calc_obuf_w(input int unsigned rd_lat);
        return $clog2(calc_obuf_depth(rd_lat) + 1);
    endfunction

    // Width of the fill level, which can reach MEM_DEPTH + OBUF_DEPTH
    function automatic int unsigned calc_lvl_w(input int unsigned depth,
                                               input int unsigned rd_lat);
        return $clog2(depth + calc_obuf_depth(rd_lat) + 1);
    endfunction

    // Advance a pointer {wrap, addr}; at depth-1 it returns to {~wrap, 0}
    // so depths that are not a power of two still wrap correctly.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr,
                                            input int unsigned depth,
                                            input int unsigned ptr_w);
        logic [31:0] w_addr;
        logic        w_wrap;
        w_addr = ptr & ((32'd1 << ptr_w) - 32'd1);
        w_wrap = ptr[ptr_w];
        if (w_addr == depth - 1) begin
            return 32'(~w_wrap) << ptr_w;
        end
        return ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsram_sdp.sv
`default_nettype none
// ============================================================================
// Module      : bsram_sdp
// Description : Inferred simple-dual-port RAM. Port A writes, port B reads
//               with a registered output and RD_LATENCY cycles total latency.
// Revision    : 1.0 - initial release
// ============================================================================
module bsram_sdp
    import fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 11,
    parameter  int unsigned MEM_DEPTH  = 16,
    parameter  int unsigned RD_LATENCY = 4,
    localparam int unsigned ADDR_W     = calc_ptr_w(MEM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  i_a_we,
    input  logic [ADDR_W-1:0]     i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_data,
    input  logic [ADDR_W-1:0]     i_b_addr,
    output logic [DATA_WIDTH-1:0] o_b_data
);

    logic [DATA_WIDTH-1:0] r_mem   [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_stage [RD_LATENCY];

    // Write port A
    always_ff @(posedge clk_i) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_data;
        end
    end

    // Read port B: registered read followed by RD_LATENCY-1 pipeline stages
    always_ff @(posedge clk_i) begin
        r_stage[0] <= r_mem[i_b_addr];
        for (int i = 1; i < RD_LATENCY; i++) begin
            r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_b_data = r_stage[RD_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/fifo_bsram_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_bsram_stream
// Description : Block-RAM streaming FIFO with ready/valid on both sides.
//               Reads are issued against credits so the output skid buffer
//               can always absorb every in-flight RAM read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_bsram_stream
    import fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH    = 11,
    parameter  int unsigned MEM_DEPTH     = 16,
    parameter  int unsigned RD_LATENCY    = 4,
    parameter  int unsigned AFULL_THRESH  = MEM_DEPTH - 2,
    parameter  int unsigned AEMPTY_THRESH = 2,
    localparam int unsigned LVL_W         = calc_lvl_w(MEM_DEPTH, RD_LATENCY)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic                  flush_i,
    output logic [LVL_W-1:0]      level_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o
);

    localparam int unsigned PTR_W      = calc_ptr_w(MEM_DEPTH);
    localparam int unsigned OBUF_DEPTH = calc_obuf_depth(RD_LATENCY);
    localparam int unsigned OBUF_W     = calc_obuf_w(RD_LATENCY);

    localparam logic [OBUF_W:0]  c_credit_max = (OBUF_W+1)'(OBUF_DEPTH);
    localparam logic [LVL_W-1:0] c_afull_lvl  = LVL_W'(AFULL_THRESH);
    localparam logic [LVL_W-1:0] c_aempty_lvl = LVL_W'(AEMPTY_THRESH);

    logic [PTR_W:0]          r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]          w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic                    w_mem_empty, w_mem_full;
    logic                    w_wr_acc, w_rd_issue, w_push, w_pop;
    logic [OBUF_W-1:0]       r_inflight, r_obuf_cnt, w_obuf_wr_idx;
    logic [OBUF_W:0]         w_credit_used;
    logic [RD_LATENCY-1:0]   r_vpipe;
    logic [DATA_WIDTH-1:0]   r_obuf     [OBUF_DEPTH];
    logic [DATA_WIDTH-1:0]   w_obuf_nxt [OBUF_DEPTH];
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic [LVL_W-1:0]        r_level;
    logic                    r_overflow;

    assign w_wr_ptr_nxt = (PTR_W+1)'(ptr_inc(32'(r_wr_ptr), MEM_DEPTH, PTR_W));
    assign w_rd_ptr_nxt = (PTR_W+1)'(ptr_inc(32'(r_rd_ptr), MEM_DEPTH, PTR_W));

    assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
    assign w_mem_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                         (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);

    // Writes in a flush cycle are discarded, including the RAM write itself
    assign w_wr_acc = valid_i && !w_mem_full && !flush_i;

    // Credits are taken from registered state only, never from ready_i
    assign w_credit_used = {1'b0, r_inflight} + {1'b0, r_obuf_cnt};
    assign w_rd_issue    = !w_mem_empty && (w_credit_used < c_credit_max);

    assign w_push  = r_vpipe[RD_LATENCY-1];
    assign valid_o = (r_obuf_cnt != '0);
    assign w_pop   = valid_o && ready_i;
    assign data_o  = r_obuf[0];

    assign ready_o        = !w_mem_full;
    assign level_o        = r_level;
    assign almost_full_o  = (r_level >= c_afull_lvl);
    assign almost_empty_o = (r_level <= c_aempty_lvl);
    assign overflow_o     = r_overflow;

    bsram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_ram (
        .clk_i    (clk_i),
        .i_a_we   (w_wr_acc),
        .i_a_addr (r_wr_ptr[PTR_W-1:0]),
        .i_a_data (data_i),
        .i_b_addr (r_rd_ptr[PTR_W-1:0]),
        .o_b_data (w_rd_data)
    );

    // Write and read pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc)   r_wr_ptr <= w_wr_ptr_nxt;
            if (w_rd_issue) r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    // Read-valid pipeline, credit counters, fill level and sticky overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vpipe    <= '0;
            r_inflight <= '0;
            r_obuf_cnt <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (flush_i) begin
            r_vpipe    <= '0;
            r_inflight <= '0;
            r_obuf_cnt <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_vpipe    <= (r_vpipe << 1) | RD_LATENCY'(w_rd_issue);
            r_inflight <= r_inflight + OBUF_W'(w_rd_issue) - OBUF_W'(w_push);
            r_obuf_cnt <= r_obuf_cnt + OBUF_W'(w_push) - OBUF_W'(w_pop);
            r_level    <= r_level + LVL_W'(w_wr_acc) - LVL_W'(w_pop);
            if (valid_i && w_mem_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Skid buffer next state: shift down on pop, land the RAM word behind the tail
    always_comb begin
        w_obuf_nxt = r_obuf;
        if (w_pop) begin
            for (int i = 0; i < OBUF_DEPTH - 1; i++) begin
                w_obuf_nxt[i] = r_obuf[i+1];
            end
        end
        w_obuf_wr_idx = r_obuf_cnt - OBUF_W'(w_pop);
        if (w_push) begin
            w_obuf_nxt[w_obuf_wr_idx] = w_rd_data;
        end
    end

    // Skid buffer storage; entry 0 drives data_o directly
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_obuf <= '{default: '0};
        end else if (!flush_i) begin
            r_obuf <= w_obuf_nxt;
        end
    end

endmodule
`default_nettype wire
